program_loader: RTL
===================

Name: program_loader

Overview:
- Front-panel programming sequencer that sits directly upstream of the 16x8 RAM.
- Drives the RAM's manual-mode controls: `manual_mode`, `manual_read` (write strobe), `address` and `program_switches`.
- Lets an operator enter a program byte-by-byte using the data switches plus debounced WRITE and SKIP buttons.
- Auto-increments the address and reports completion after address 15.

Parameters:
- ADDR_W, 4, RAM address width (16 locations).
- DATA_W, 8, RAM word width.
- DEBOUNCE_CYCLES, 1000000, number of stable cycles required before a button change is accepted; the bench uses 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- load_enable  in  1  operator "program mode" switch, level-sensitive
- write_btn  in  1  raw asynchronous pushbutton; stores switches at the current address
- skip_btn  in  1  raw asynchronous pushbutton; advances the address without writing
- data_switches  in  DATA_W  raw operator data switches
- mem_data  in  DATA_W  RAM combinational read data (RAM `bus_out`), used only with readback
- manual_mode  out  1  to RAM manual_mode
- manual_read  out  1  to RAM manual_read; one-cycle write strobe
- address  out  ADDR_W  to RAM address
- program_switches  out  DATA_W  to RAM program_switches; registered data
- load_done  out  1  high after address 15 has been written or skipped
- verify_error  out  1  sticky readback mismatch flag; tied 0 when the feature is off

Behaviour:
- Reset (rst_n=0 at a posedge): all outputs 0 and state IDLE; reset always wins.
- Button conditioning:
  - Each button passes through a 2-FF synchronizer, then a debouncer.
  - Level is accepted after DEBOUNCE_CYCLES consecutive equal samples.
  - Rising edge of the accepted level produces a 1-cycle pulse (wr_p, sk_p).
  - Holding a button yields exactly one pulse.
- States IDLE, ARMED, WRITE, VERIFY, DONE:
  - IDLE: manual_mode=0. On load_enable=1, go to ARMED with address=0, load_done=0, verify_error=0.
  - ARMED: manual_mode=1, manual_read=0.
    - On wr_p, register data_switches into program_switches and go to WRITE.
    - Else on sk_p, advance.
    - If wr_p and sk_p occur in the same cycle, the write wins and the skip is dropped.
  - WRITE: exactly one cycle with manual_read=1; address and program_switches stay stable, so the RAM captures on the next posedge. Next state is VERIFY if the feature is enabled, else advance.
  - VERIFY: manual_read=0, address unchanged. On mismatch set verify_error, then advance.
  - Advance: if address==15, go to DONE, leave address at 15 and set load_done=1. Otherwise address+1 and go to ARMED. The address never wraps inside a pass.
  - DONE: manual_mode=1 and button pulses are ignored. On load_enable=0, go to IDLE.
- load_enable=0 in any state: next cycle is IDLE with manual_mode=0 and manual_read=0, and any pending strobe is aborted. The address and data registers hold. load_done and verify_error are cleared only on re-entry to ARMED.
- Latency:
  - Button press to manual_read is DEBOUNCE_CYCLES + 3 cycles, nominally.
  - wr_p to manual_read is 1 cycle.
  - The RAM write lands on the posedge ending the WRITE cycle.

Optional Feature:
- Macro: LOADER_READBACK_EN.
- Defined: the VERIFY state exists. One cycle after WRITE, mem_data is compared against program_switches; on inequality verify_error is set, sticky until the next ARMED entry from IDLE.
- Undefined: the VERIFY state is not compiled, WRITE advances directly, verify_error is driven 0 and mem_data is unused.

Decomposition:
- Package loader_pkg:
  - State enum loader_state_e.
  - ADDR_W and DATA_W defaults.
  - LAST_ADDR constant (15).
- Sub-module button_debouncer (parameter DEBOUNCE_CYCLES; ports clk, rst_n, btn_raw, btn_level, btn_rise), instantiated twice.

Test Plan:
- Basic write:
  - Stimulus: reset, load_enable=1, switches=0x5F, press write.
  - Required: exactly one manual_read pulse with address=0 and program_switches=0x5F; address then becomes 1.
- Skip/bounce:
  - Stimulus: toggle skip_btn 1-0-1 within 3 cycles, then hold high.
  - Required: one address increment only (0→1); manual_read never asserted.
- Full pass:
  - Stimulus: 16 writes, values 0x10..0x1F.
  - Required: RAM model holds 0x10..0x1F at addresses 0..15; load_done=1; address=15; further presses do nothing.
- Simultaneous/abort:
  - Stimulus: write and skip pulses in the same cycle at address 3.
  - Required: write to 3 and address becomes 4.
  - Stimulus: drop load_enable during WRITE.
  - Required: manual_mode=0 and manual_read=0 the next cycle.
- Reset mid-operation:
  - Stimulus: rst_n=0 at address 7 in ARMED.
  - Required: all outputs 0 the next cycle; state IDLE.
- Readback (LOADER_READBACK_EN):
  - Stimulus: RAM model forces mem_data=0x00 after a write of 0xA5.
  - Required: verify_error=1 and it stays 1; the matching case keeps it 0.

Source files
------------

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the front-panel program
//                loader. Optional macro: LOADER_READBACK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int LOADER_ADDR_W = 4;
    localparam int LOADER_DATA_W = 8;
    localparam int LAST_ADDR     = 15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_WRITE  = 3'd2,
`ifdef LOADER_READBACK_EN
        ST_VERIFY = 3'd3,
`endif
        ST_DONE   = 3'd4
    } loader_state_e;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : 2-FF synchronizer, stable-count debouncer and rising-edge
//                pulse for one raw pushbutton.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;
    logic               r_rise;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any bounce back to the accepted level restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], btn_raw};
            r_rise <= 1'b0;
            if (r_sync[1] != r_level) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_level <= r_sync[1];
                    r_cnt   <= '0;
                    r_rise  <= r_sync[1];
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign btn_level = r_level;
    assign btn_rise  = r_rise;

endmodule : button_debouncer
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Front-panel sequencer driving the 16x8 RAM manual-mode port.
//                Optional macro: LOADER_READBACK_EN (post-write verify).
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W          = LOADER_ADDR_W,
    parameter int DATA_W          = LOADER_DATA_W,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_enable,
    input  logic              write_btn,
    input  logic              skip_btn,
    input  logic [DATA_W-1:0] data_switches,
    input  logic [DATA_W-1:0] mem_data,
    output logic              manual_mode,
    output logic              manual_read,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] program_switches,
    output logic              load_done,
    output logic              verify_error
);

    loader_state_e     r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_done, w_done_nxt;
    logic              w_advance;
    logic              w_wr_p, w_sk_p;
    logic              w_wr_level, w_sk_level;
    logic              w_unused;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wr_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (write_btn),
        .btn_level (w_wr_level),
        .btn_rise  (w_wr_p)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sk_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (skip_btn),
        .btn_level (w_sk_level),
        .btn_rise  (w_sk_p)
    );

    assign w_unused = ^{mem_data, w_wr_level, w_sk_level};

`ifdef LOADER_READBACK_EN
    logic r_verr, w_verr_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_data <= '0;
            r_done <= 1'b0;
`ifdef LOADER_READBACK_EN
            r_verr <= 1'b0;
`endif
        end else begin
            r_addr <= w_addr_nxt;
            r_data <= w_data_nxt;
            r_done <= w_done_nxt;
`ifdef LOADER_READBACK_EN
            r_verr <= w_verr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_done_nxt  = r_done;
        w_advance   = 1'b0;
`ifdef LOADER_READBACK_EN
        w_verr_nxt  = r_verr;
`endif
        if (!load_enable) begin
            // Dropping program mode aborts everything but keeps addr/data.
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ARMED;
                    w_addr_nxt  = '0;
                    w_done_nxt  = 1'b0;
`ifdef LOADER_READBACK_EN
                    w_verr_nxt  = 1'b0;
`endif
                end
                ST_ARMED: begin
                    if (w_wr_p) begin
                        w_data_nxt  = data_switches;
                        w_state_nxt = ST_WRITE;
                    end else if (w_sk_p) begin
                        w_advance = 1'b1;
                    end
                end
                ST_WRITE: begin
`ifdef LOADER_READBACK_EN
                    w_state_nxt = ST_VERIFY;
`else
                    w_advance = 1'b1;
`endif
                end
`ifdef LOADER_READBACK_EN
                ST_VERIFY: begin
                    if (mem_data != r_data) begin
                        w_verr_nxt = 1'b1;
                    end
                    w_advance = 1'b1;
                end
`endif
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            if (w_advance) begin
                if (r_addr == ADDR_W'(LAST_ADDR)) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    w_state_nxt = ST_ARMED;
                end
            end
        end
    end

    assign manual_mode      = (r_state != ST_IDLE);
    assign manual_read      = (r_state == ST_WRITE);
    assign address          = r_addr;
    assign program_switches = r_data;
    assign load_done        = r_done;
`ifdef LOADER_READBACK_EN
    assign verify_error     = r_verr;
`else
    assign verify_error     = 1'b0;
`endif

endmodule : program_loader
`default_nettype wire
